// File: rtl/ahb2_apb_bridge.sv
// ahb2_apb_bridge
//   AHB2 slave that turns single AHB transfers into APB4 SETUP/ACCESS
//   sequences, one transfer at a time, stalling the AHB data phase with
//   hreadyo=0 until the APB completer answers. An APB pslverr, or an
//   unsupported hsize, becomes a two-cycle AHB ERROR response.
//
// Ports
//   clk, rst            : single clock, async active-high reset
//   hsel..hreadyi       : AHB slave-side inputs (hburst/hprot ignored)
//   hreadyo/hrdata/hresp: AHB slave response (all registered)
//   psel..pstrb         : APB requester outputs (all registered)
//   prdata/pready/pslverr: APB completer response
module ahb2_apb_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [31:0]       hwdata,
  input  logic              hreadyi,
  output logic              hreadyo,
  output logic [31:0]       hrdata,
  output logic [1:0]        hresp,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_RESP, S_ERR1, S_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                hreadyo_q, hreadyo_d;
  logic [1:0]          hresp_q, hresp_d;
  logic [31:0]         hrdata_q, hrdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [3:0]          pstrb_q, pstrb_d;

  logic                accept;
  logic                size_bad;
  logic [3:0]          strb;

  // Burst type, protection and the SEQ/NONSEQ distinction play no role.
  logic unused_in;
  assign unused_in = ^{hburst, hprot, htrans[0]};

  // hreadyo_q is only high in IDLE/RESP/ERR2, so it doubles as the
  // "may take a new address phase" qualifier.
  assign accept   = hsel & htrans[1] & hreadyi & hreadyo_q;
  assign size_bad = hsize[2] | (&hsize[1:0]);

  always_comb begin
    strb = 4'h0;
    if (write_q) begin
      case (size_q)
        2'd0:    strb = 4'b0001 << addr_q[1:0];
        2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: strb = 4'hF;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    hrdata_d = hrdata_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;

    case (state_q)
      S_IDLE, S_RESP, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          addr_d  = haddr;
          write_d = hwrite;
          size_d  = hsize[1:0];
          state_d = size_bad ? S_ERR1 : S_LATCH;
        end
      end
      S_LATCH: begin
        // APB address/control/data are frozen here until the next LATCH.
        paddr_d  = addr_q;
        pwrite_d = write_q;
        pwdata_d = write_q ? hwdata : 32'h0;
        pstrb_d  = strb;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          if (!write_q) hrdata_d = prdata;
          state_d = pslverr ? S_ERR1 : S_RESP;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    hreadyo_d = state_d inside {S_IDLE, S_RESP, S_ERR2};
    hresp_d   = (state_d inside {S_ERR1, S_ERR2}) ? 2'b01 : 2'b00;
    psel_d    = state_d inside {S_SETUP, S_ACCESS};
    penable_d = (state_d == S_ACCESS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      hreadyo_q <= 1'b1;
      hresp_q   <= 2'b00;
      hrdata_q  <= 32'h0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'h0;
      pstrb_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      hreadyo_q <= hreadyo_d;
      hresp_q   <= hresp_d;
      hrdata_q  <= hrdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
    end
  end

  assign hreadyo = hreadyo_q;
  assign hresp   = hresp_q;
  assign hrdata  = hrdata_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;

endmodule

// File: tb/tb_ahb2_apb_bridge.sv
// Bench for ahb2_apb_bridge: directed AHB transfers, a reactive APB
// completer, and a per-cycle timeline model of the expected outputs.
module tb_ahb2_apb_bridge;
  localparam int N = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hreadyi;
  logic        hreadyo;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  always #5 clk = ~clk;

  ahb2_apb_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwdata(hwdata), .hreadyi(hreadyi), .hreadyo(hreadyo), .hrdata(hrdata),
    .hresp(hresp), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  bit          e_rdy [N];
  bit          e_err [N];
  bit          e_psel[N];
  bit          e_pen [N];
  bit          u_apb [N];
  logic [31:0] u_paddr [N];
  bit          u_pwrite[N];
  logic [31:0] u_pwdata[N];
  logic [3:0]  u_pstrb [N];
  bit          u_rd    [N];
  logic [31:0] u_rdata [N];
  logic [31:0] m_paddr = 0, m_pwdata = 0, m_hrdata = 0;
  logic        m_pwrite = 0;
  logic [3:0]  m_pstrb = 0;

  function automatic void clear_from(input int s);
    for (int i = s; i < N; i++) begin
      e_rdy[i] = 1; e_err[i] = 0; e_psel[i] = 0; e_pen[i] = 0;
      u_apb[i] = 0; u_rd[i] = 0;
    end
  endfunction

  // Byte lanes touched: 2**size bytes starting at the size-aligned offset.
  function automatic logic [3:0] exp_strb(input logic [31:0] a, input bit wr, input logic [2:0] sz);
    int nb, first;
    logic [3:0] s;
    s = 4'h0;
    if (!wr) return s;
    nb = 1 << sz;
    first = int'(a[1:0]) & ~(nb - 1);
    for (int i = 0; i < 4; i++)
      if (i >= first && i < first + nb) s[i] = 1'b1;
    return s;
  endfunction

  // Transfer accepted at the end of cycle A; w APB wait states.
  function automatic void model_add(input int A, input logic [31:0] a, input bit wr,
                                    input logic [2:0] sz, input logic [31:0] wd,
                                    input int w, input bit e, input logic [31:0] rd);
    int c;
    if (sz >= 3) begin
      e_rdy[A+1] = 0; e_err[A+1] = 1; e_err[A+2] = 1;
    end else begin
      for (int k = A + 1; k <= A + 3 + w; k++) e_rdy[k] = 0;
      for (int k = A + 2; k <= A + 3 + w; k++) e_psel[k] = 1;
      for (int k = A + 3; k <= A + 3 + w; k++) e_pen[k] = 1;
      c = A + 4 + w;
      if (e) begin e_rdy[c] = 0; e_err[c] = 1; e_err[c+1] = 1; end
      u_apb[A+2] = 1; u_paddr[A+2] = a; u_pwrite[A+2] = wr;
      u_pwdata[A+2] = wr ? wd : 32'h0; u_pstrb[A+2] = exp_strb(a, wr, sz);
      if (!wr) begin u_rd[c] = 1; u_rdata[c] = rd; end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en && !rst && cyc < N) begin
      if (u_apb[cyc]) begin
        m_paddr = u_paddr[cyc]; m_pwrite = u_pwrite[cyc];
        m_pwdata = u_pwdata[cyc]; m_pstrb = u_pstrb[cyc];
      end
      if (u_rd[cyc]) m_hrdata = u_rdata[cyc];
      chk("m_hreadyo", 32'(hreadyo), 32'(e_rdy[cyc]));
      chk("m_hresp",   32'(hresp),   32'(e_err[cyc]));
      chk("m_psel",    32'(psel),    32'(e_psel[cyc]));
      chk("m_penable", 32'(penable), 32'(e_pen[cyc]));
      chk("m_paddr",   paddr,        m_paddr);
      chk("m_pwrite",  32'(pwrite),  32'(m_pwrite));
      chk("m_pwdata",  pwdata,       m_pwdata);
      chk("m_pstrb",   32'(pstrb),   32'(m_pstrb));
      chk("m_hrdata",  hrdata,       m_hrdata);
    end
  end

  // ---------------- APB completer ----------------
  int          cur_w = 0;
  bit          cur_e = 0;
  logic [31:0] cur_rd = 0;
  int          acc_cnt = 0;

  initial begin
    pready = 0; pslverr = 0; prdata = 0;
    forever begin
      @(negedge clk);
      if (rst || !(psel && penable)) begin
        acc_cnt = 0; pready = 0; pslverr = 0;
      end else begin
        pready  = (acc_cnt == cur_w);
        pslverr = (acc_cnt == cur_w) && cur_e;
        acc_cnt++;
      end
      prdata = cur_rd;
    end
  end

  // ---------------- AHB driver ----------------
  // Returns at the negedge of the first data-phase cycle (A+1).
  task automatic xfer(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                      input logic [31:0] wd, input int w, input bit e, input logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    while (!hreadyo && n < 64) begin @(negedge clk); n++; end
    if (!hreadyo) begin
      checks++; errors++;
      $display("FAIL accept_timeout hreadyo=%b required=1 cyc=%0d", hreadyo, cyc);
    end
    hsel = 1; htrans = 2'd2; haddr = a; hwrite = wr; hsize = sz;
    cur_w = w; cur_e = e; cur_rd = rd;
    model_add(cyc, a, wr, sz, wd, w, e, rd);
    @(negedge clk);
    hsel = 0; htrans = 2'd0; hwdata = wd;
  endtask

  initial begin
    rst = 1; hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0;
    hburst = 0; hprot = 0; hwdata = 0; hreadyi = 1;
    clear_from(0);
    repeat (3) @(negedge clk);
    chk("rst_hreadyo", 32'(hreadyo), 32'd1);
    chk("rst_hresp",   32'(hresp),   32'd0);
    chk("rst_hrdata",  hrdata,       32'd0);
    chk("rst_psel",    32'(psel),    32'd0);
    chk("rst_pstrb",   32'(pstrb),   32'd0);
    chk("rst_paddr",   paddr,        32'd0);
    rst = 0;
    chk_en = 1;

    // Word write, zero-wait APB
    xfer(32'h40, 1, 3'd2, 32'hDEADBEEF, 0, 0, 0);
    chk("ww_a1_hreadyo", 32'(hreadyo), 32'd0);
    @(negedge clk);
    chk("ww_a2_psel",    32'(psel),    32'd1);
    chk("ww_a2_penable", 32'(penable), 32'd0);
    @(negedge clk);
    chk("ww_a3_penable", 32'(penable), 32'd1);
    chk("ww_paddr",      paddr,        32'h40);
    chk("ww_pwdata",     pwdata,       32'hDEADBEEF);
    chk("ww_pstrb",      32'(pstrb),   32'hF);
    @(negedge clk);
    chk("ww_a4_hreadyo", 32'(hreadyo), 32'd1);
    chk("ww_a4_hresp",   32'(hresp),   32'd0);

    // Read with 2 APB wait states
    xfer(32'h44, 0, 3'd2, 32'h0, 2, 0, 32'h12345678);
    repeat (5) @(negedge clk);
    chk("rd_a6_hrdata",  hrdata,       32'h12345678);
    chk("rd_a6_hreadyo", 32'(hreadyo), 32'd1);
    chk("rd_a6_hresp",   32'(hresp),   32'd0);

    // Strobes
    xfer(32'h43, 1, 3'd0, 32'hAA00_0000, 0, 0, 0);
    @(negedge clk);
    chk("byte_pstrb", 32'(pstrb), 32'b1000);
    xfer(32'h42, 1, 3'd1, 32'hBBBB_0000, 1, 0, 0);
    @(negedge clk);
    chk("half_pstrb", 32'(pstrb), 32'b1100);
    xfer(32'h48, 0, 3'd2, 32'h5555_5555, 0, 0, 32'hCAFEF00D);
    @(negedge clk);
    chk("read_pstrb",  32'(pstrb), 32'b0000);
    chk("read_pwdata", pwdata,     32'h0);

    // APB slave error
    xfer(32'h50, 1, 3'd2, 32'h11, 0, 1, 0);
    repeat (3) @(negedge clk);
    chk("err_a4_hresp",   32'(hresp),   32'd1);
    chk("err_a4_hreadyo", 32'(hreadyo), 32'd0);
    @(negedge clk);
    chk("err_a5_hresp",   32'(hresp),   32'd1);
    chk("err_a5_hreadyo", 32'(hreadyo), 32'd1);
    @(negedge clk);
    chk("err_a6_hresp",   32'(hresp),   32'd0);
    chk("err_a6_hreadyo", 32'(hreadyo), 32'd1);

    // Unsupported size
    xfer(32'h54, 1, 3'd3, 32'h22, 0, 0, 0);
    chk("sz3_a1_hresp",   32'(hresp),   32'd1);
    chk("sz3_a1_hreadyo", 32'(hreadyo), 32'd0);
    chk("sz3_a1_psel",    32'(psel),    32'd0);
    @(negedge clk);
    chk("sz3_a2_hresp",   32'(hresp),   32'd1);
    chk("sz3_a2_hreadyo", 32'(hreadyo), 32'd1);
    chk("sz3_a2_psel",    32'(psel),    32'd0);

    // Error followed by a transfer issued in ERR2
    xfer(32'h58, 0, 3'd2, 32'h0, 1, 1, 32'h0BAD_0BAD);
    xfer(32'h5C, 1, 3'd1, 32'h7777_8888, 0, 0, 0);

    // Back-to-back: second NONSEQ issued in the RESP cycle
    xfer(32'h60, 1, 3'd2, 32'h1, 0, 0, 0);
    xfer(32'h64, 0, 3'd2, 32'h0, 1, 0, 32'h5A5A5A5A);
    chk("b2b_latch_hreadyo", 32'(hreadyo), 32'd0);
    @(negedge clk);
    chk("b2b_setup_psel", 32'(psel), 32'd1);
    chk("b2b_paddr",      paddr,     32'h64);
    repeat (4) @(negedge clk);

    // Gating: BUSY, then NONSEQ with hreadyi low
    hsel = 1; htrans = 2'd1; haddr = 32'h70; hwrite = 1; hsize = 3'd2;
    @(negedge clk);
    chk("busy_hreadyo", 32'(hreadyo), 32'd1);
    htrans = 2'd2; hreadyi = 0;
    @(negedge clk);
    chk("gate_hreadyo", 32'(hreadyo), 32'd1);
    hsel = 0; htrans = 2'd0; hreadyi = 1;
    repeat (2) @(negedge clk);
    chk("gate_psel", 32'(psel), 32'd0);

    // Async reset in ACCESS
    xfer(32'h80, 0, 3'd2, 32'h0, 3, 0, 32'h77);
    repeat (2) @(negedge clk);
    chk("rs_access_penable", 32'(penable), 32'd1);
    #1 rst = 1;
    #1;
    chk("rs_psel",    32'(psel),    32'd0);
    chk("rs_penable", 32'(penable), 32'd0);
    chk("rs_hreadyo", 32'(hreadyo), 32'd1);
    chk("rs_hresp",   32'(hresp),   32'd0);
    clear_from(cyc);
    m_paddr = 0; m_pwdata = 0; m_hrdata = 0; m_pwrite = 0; m_pstrb = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    xfer(32'h84, 1, 3'd2, 32'h13579BDF, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("post_rs_hreadyo", 32'(hreadyo), 32'd1);
    chk("post_rs_hresp",   32'(hresp),   32'd0);
    chk("post_rs_pwdata",  pwdata,       32'h13579BDF);
    chk("post_rs_hrdata",  hrdata,       32'h0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb2_apb_bridge.md
# ahb2_apb_bridge

AHB2 slave that converts single AHB2 transfers into APB4 accesses. It sits downstream of the AHB2 bus and attaches to the bus's slave-side signals (`hsel`, `haddr`, `htrans`, …, `hreadyi`/`hreadyo`). It serialises one AHB transfer at a time into an APB SETUP/ACCESS sequence, inserting AHB wait states until the APB completer responds. APB `pslverr` is returned as a two-cycle AHB ERROR response.

## Interface
- `ADDR_W`, default 32: AHB/APB address width. The data path is fixed at 32 bits.
- `clk` in 1: single clock for the AHB and APB sides.
- `rst` in 1: asynchronous, active-high reset.
- `hsel` in 1: slave select.
- `haddr` in ADDR_W: address.
- `htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 0 = byte, 1 = half, 2 = word; 3 and above are unsupported.
- `hburst` in 3: ignored; every beat is treated independently.
- `hprot` in 4: ignored.
- `hwdata` in 32: write data, valid in the data phase.
- `hreadyi` in 1: bus HREADY input.
- `hreadyo` out 1: slave ready.
- `hrdata` out 32: read data.
- `hresp` out 2: OKAY=00, ERROR=01.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `paddr` out ADDR_W: APB address.
- `pwrite` out 1: APB direction.
- `pwdata` out 32: APB write data.
- `pstrb` out 4: APB byte strobes.
- `prdata` in 32: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.

## Operation
- **Accept condition:** `hsel & htrans[1] & hreadyi & hreadyo`. BUSY and IDLE transfers are never accepted.
- **Captured on accept:** `haddr`, `hwrite`, `hsize` go into address-phase registers.
- **FSM states:** IDLE, LATCH, SETUP, ACCESS, RESP, ERR1, ERR2. All outputs are registered.
- **IDLE:** `hreadyo=1`, `hresp=OKAY`.
  - Accept with `hsize<=2` → LATCH.
  - Accept with `hsize>=3` → ERR1. No APB access occurs.
- **LATCH** (first data-phase cycle): `hreadyo=0`.
  - Register `hwdata` into `pwdata`. For reads `pwdata` is written with 0.
  - Drive `paddr`, `pwrite` and `pstrb`.
  - Go to SETUP.
- **SETUP:** `psel=1`, `penable=0`. Go to ACCESS.
- **ACCESS:** `psel=1`, `penable=1`. Stay while `pready=0`.
  - On `pready=1`: deassert `psel`/`penable` at the next edge.
  - On `pready=1` with a read: `hrdata<=prdata`.
  - Next state is ERR1 if `pslverr`, else RESP.
- **RESP:** `hreadyo=1`, `hresp=OKAY`; completes the data phase.
  - Accept in this cycle → LATCH or ERR1, by the same `hsize` rule as IDLE.
  - Otherwise → IDLE.
- **ERR1:** `hreadyo=0`, `hresp=ERROR`. Go to ERR2.
- **ERR2:** `hreadyo=1`, `hresp=ERROR`. The accept rule is the same as RESP, so the master may issue a new transfer or cancel with IDLE.
- **`pstrb` rules:**
  - Reads: 0.
  - Byte writes: `4'b0001 << haddr[1:0]`.
  - Half writes: `4'b0011 << {haddr[1],1'b0}`.
  - Word writes: `4'hF`.
  - Unaligned half/word addresses are not checked; low address bits are passed through on `paddr`.
- **`hrdata`:** holds its value between reads and is not cleared on writes.
- **APB stable signals:** `paddr`, `pwrite`, `pwdata` and `pstrb` hold from LATCH until the next LATCH.
- **Reset:** while `rst=1` (asynchronous) the block forces:
  - state = IDLE;
  - `hreadyo=1`, `hresp=00`, `hrdata=0`;
  - `psel=0`, `penable=0`;
  - `paddr=0`, `pwrite=0`, `pwdata=0`, `pstrb=0`.
  - Reset mid-ACCESS drops `psel`/`penable` immediately and completes no AHB response.

## Timing
- **Zero-wait APB:** accept at cycle A, LATCH at A+1, SETUP at A+2, ACCESS at A+3 (with `pready=1`), RESP at A+4 (`hreadyo=1`).
  - That is 3 AHB wait states plus the completing cycle.
  - Each extra APB wait state adds one AHB wait state.
- **Back-to-back transfers:** a transfer accepted in RESP enters LATCH the next cycle. Peak throughput is one transfer per 4 cycles.
- **Error path:**
  - ACCESS with `pready & pslverr`, then ERR1 (`hreadyo=0`, ERROR), then ERR2 (`hreadyo=1`, ERROR).
  - Unsupported `hsize` goes accept → ERR1 → ERR2, so the response is 2 cycles after accept.
- **hreadyi gating:** when `hreadyi=0` in IDLE/RESP/ERR2 nothing is accepted, even if `htrans=NONSEQ`.
- **hrdata timing:** `hrdata` is valid in the RESP cycle and afterwards.

## Test plan
- **Word write:** accept `haddr=0x40`, `hwrite=1`, `hsize=2`, then `hwdata=0xDEADBEEF` in the next cycle, zero-wait APB.
  - Required: `psel` high with `penable` low at A+2 and `penable` high at A+3.
  - Required: `paddr=0x40`, `pwdata=0xDEADBEEF`, `pstrb=F`; `hreadyo` low A+1..A+3 and high with OKAY at A+4.
- **Read with 2 APB waits:** accept `haddr=0x44`, read; `pready=0` for 2 ACCESS cycles, then `prdata=0x12345678` with `pready=1`.
  - Required: `hrdata=0x12345678` with `hreadyo=1`, OKAY at A+6.
- **Byte and half strobes:**
  - Byte write at `0x43` → `pstrb=1000`.
  - Half write at `0x42` → `pstrb=1100`.
  - Read → `pstrb=0000`.
- **APB slave error:** write with `pslverr=1` on `pready`.
  - Required: `hresp=01` for two cycles with `hreadyo` 0 then 1, then IDLE.
  - Unsupported size: `hsize=3` → ERROR pair with no `psel` assertion.
- **Back-to-back and gating:**
  - NONSEQ issued in the RESP cycle → LATCH next cycle; a second APB access starts at RESP+2.
  - `htrans=BUSY`, or `hreadyi=0`, → no accept.
- **Async reset:** assert `rst` in ACCESS.
  - Required: `psel`/`penable` low before the next edge, `hreadyo=1`, `hresp=00`.
  - Required after release: a new transfer completes normally.
